// File: rtl/mem_read_arbiter_if.sv
// Bundles the two requester ports, the flush and the shared memory read port.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mem_read_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    logic                  flush0;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, flush0, mem_rd_data,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data, mem_rd_addr
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, flush0, mem_rd_data,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data, mem_rd_addr
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one synchronous memory read port between fetch (0) and load (1).
// A {valid, port} tag pipe of depth RD_LATENCY steers returning data; flush0 squashes port-0 reads.
module mem_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_read_arbiter_if.slave   bus
);
    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

    tag_t                  pipe [RD_LATENCY];
    tag_t                  stage_in;
    tag_t                  out_tag;
    logic                  last_grant;
    logic                  grant_valid;
    logic                  grant_port;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rsp0_q;
    logic [DATA_WIDTH-1:0] rsp1_q;
    logic                  rsp0_hit;
    logic                  rsp1_hit;

    // A port-0 tag loses its valid bit whenever flush0 is high, wherever it sits.
    function automatic tag_t squash(input tag_t t, input logic kill0);
        tag_t r;
        r = t;
        if (kill0 && !t.port) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_port  = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b1;
            end
        end
    end

    assign grant_addr      = grant_port ? bus.req1_addr : bus.req0_addr;
    assign bus.req0_ready  = grant_valid && !grant_port;
    assign bus.req1_ready  = grant_valid &&  grant_port;
    // Idle cycles replay the last issued address so the memory bus stays quiet.
    assign bus.mem_rd_addr = grant_valid ? grant_addr : addr_q;

    assign stage_in = squash(tag_t'{valid: grant_valid, port: grant_port}, bus.flush0);
    assign out_tag  = pipe[RD_LATENCY-1];
    assign rsp0_hit = out_tag.valid && !out_tag.port && !bus.flush0;
    assign rsp1_hit = out_tag.valid &&  out_tag.port;

    assign bus.rsp0_valid = rsp0_hit;
    assign bus.rsp1_valid = rsp1_hit;
    assign bus.rsp0_data  = rsp0_hit ? bus.mem_rd_data : rsp0_q;
    assign bus.rsp1_data  = rsp1_hit ? bus.mem_rd_data : rsp1_q;

    // NOTE: state is updated with non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag pipe is a handful of flops, so it is reset to drop in-flight reads.
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
            last_grant <= 1'b1;
            addr_q     <= '0;
            rsp0_q     <= '0;
            rsp1_q     <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= squash(pipe[i-1], bus.flush0);
            end
            if (grant_valid) begin
                last_grant <= grant_port;
                addr_q     <= grant_addr;
            end
            if (rsp0_hit) begin
                rsp0_q <= bus.mem_rd_data;
            end
            if (rsp1_hit) begin
                rsp1_q <= bus.mem_rd_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: three instances with RD_LATENCY 1, 2 and 3,
// each backed by a memory model returning 0xD000_0000 | addr after the configured latency.
module tb_mem_read_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
    mem_read_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b2 ();
    mem_read_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

    mem_read_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_read_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    mem_read_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    // Memory models: the address is sampled on each rising edge, data appears RD_LATENCY cycles later.
    logic [31:0] ap1 [1];
    logic [31:0] ap2 [2];
    logic [31:0] ap3 [3];

    always @(posedge clk) begin
        ap1[0] <= b1.mem_rd_addr;
        ap2[0] <= b2.mem_rd_addr;
        ap2[1] <= ap2[0];
        ap3[0] <= b3.mem_rd_addr;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end

    assign b1.mem_rd_data = mem_word(ap1[0]);
    assign b2.mem_rd_data = mem_word(ap2[1]);
    assign b3.mem_rd_data = mem_word(ap3[2]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b1.req0_valid = 0; b1.req0_addr = '0; b1.req1_valid = 0; b1.req1_addr = '0; b1.flush0 = 0;
        b2.req0_valid = 0; b2.req0_addr = '0; b2.req1_valid = 0; b2.req1_addr = '0; b2.flush0 = 0;
        b3.req0_valid = 0; b3.req0_addr = '0; b3.req1_valid = 0; b3.req1_addr = '0; b3.flush0 = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        b1.req0_valid = 1'b1;
        b1.req0_addr  = 32'h100;
        #2;
        // Reset state, with a request present to show ready is gated by reset
        check("rst_ready0",   32'(b1.req0_ready),  32'd0);
        check("rst_ready1",   32'(b1.req1_ready),  32'd0);
        check("rst_rsp0_v",   32'(b1.rsp0_valid),  32'd0);
        check("rst_rsp1_v",   32'(b1.rsp1_valid),  32'd0);
        check("rst_rsp0_d",   b1.rsp0_data,        32'd0);
        check("rst_rsp1_d",   b1.rsp1_data,        32'd0);
        check("rst_mem_addr", b1.mem_rd_addr,      32'd0);
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // 1: single port-0 read, latency 1
        b1.req0_valid = 1'b1;
        b1.req0_addr  = 32'h100;
        @(negedge clk);
        check("t1_ready0",    32'(b1.req0_ready), 32'd1);
        check("t1_ready1",    32'(b1.req1_ready), 32'd0);
        check("t1_mem_addr",  b1.mem_rd_addr,     32'h100);
        check("t1_rsp0_v_c0", 32'(b1.rsp0_valid), 32'd0);
        next_cycle();
        b1.req0_valid = 1'b0;
        @(negedge clk);
        check("t1_rsp0_v_c1", 32'(b1.rsp0_valid), 32'd1);
        check("t1_rsp0_d_c1", b1.rsp0_data,       32'hD000_0100);
        check("t1_rsp1_v_c1", 32'(b1.rsp1_valid), 32'd0);
        check("t1_ready0_c1", 32'(b1.req0_ready), 32'd0);
        next_cycle();

        // 2: both ports contending every cycle, fresh arbiter state
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            b1.req0_valid = (k < 4);
            b1.req0_addr  = 32'h10;
            b1.req1_valid = (k < 4);
            b1.req1_addr  = 32'h20;
            @(negedge clk);
            if (k < 4) begin
                check($sformatf("t2_ready0_%0d", k), 32'(b1.req0_ready), 32'((k % 2) == 0));
                check($sformatf("t2_ready1_%0d", k), 32'(b1.req1_ready), 32'((k % 2) == 1));
                check($sformatf("t2_addr_%0d", k),   b1.mem_rd_addr,     (k % 2) == 0 ? 32'h10 : 32'h20);
            end
            if (k >= 1) begin
                check($sformatf("t2_rsp0_v_%0d", k), 32'(b1.rsp0_valid), 32'(((k - 1) % 2) == 0));
                check($sformatf("t2_rsp1_v_%0d", k), 32'(b1.rsp1_valid), 32'(((k - 1) % 2) == 1));
                if (((k - 1) % 2) == 0) begin
                    check($sformatf("t2_rsp0_d_%0d", k), b1.rsp0_data, 32'hD000_0010);
                end else begin
                    check($sformatf("t2_rsp1_d_%0d", k), b1.rsp1_data, 32'hD000_0020);
                end
            end
            next_cycle();
        end
        clear_inputs();

        // 3: four back-to-back port-1 reads with latency 3
        for (int c = 0; c < 8; c++) begin
            b3.req1_valid = (c < 4);
            b3.req1_addr  = 32'(4 * c);
            @(negedge clk);
            check($sformatf("t3_ready1_%0d", c), 32'(b3.req1_ready), 32'(c < 4));
            check($sformatf("t3_rsp1_v_%0d", c), 32'(b3.rsp1_valid), 32'(c >= 3 && c <= 6));
            check($sformatf("t3_rsp0_v_%0d", c), 32'(b3.rsp0_valid), 32'd0);
            if (c >= 3 && c <= 6) begin
                check($sformatf("t3_rsp1_d_%0d", c), b3.rsp1_data, 32'hD000_0000 + 32'(4 * (c - 3)));
            end
            next_cycle();
        end
        clear_inputs();

        // 4: latency 2, port-0 read squashed by flush0 while a port-1 read goes through
        for (int c = 0; c < 5; c++) begin
            b2.req0_valid = (c == 0);
            b2.req0_addr  = 32'h40;
            b2.req1_valid = (c == 1);
            b2.req1_addr  = 32'h80;
            b2.flush0     = (c == 1);
            @(negedge clk);
            if (c == 0) check("t4_ready0", 32'(b2.req0_ready), 32'd1);
            if (c == 1) check("t4_ready1", 32'(b2.req1_ready), 32'd1);
            check($sformatf("t4_rsp0_v_%0d", c), 32'(b2.rsp0_valid), 32'd0);
            check($sformatf("t4_rsp1_v_%0d", c), 32'(b2.rsp1_valid), 32'(c == 3));
            if (c == 3) check("t4_rsp1_d", b2.rsp1_data, 32'hD000_0080);
            next_cycle();
        end
        clear_inputs();

        // 5: reset with two latency-3 reads in flight
        b3.req0_valid = 1'b1;
        b3.req0_addr  = 32'h200;
        @(negedge clk);
        check("t5_ready0_c0", 32'(b3.req0_ready), 32'd1);
        next_cycle();
        b3.req0_addr = 32'h204;
        @(negedge clk);
        check("t5_ready0_c1", 32'(b3.req0_ready), 32'd1);
        next_cycle();
        b3.req1_valid = 1'b1;
        b3.req1_addr  = 32'h300;
        rst = 1'b1;
        #1;
        check("t5_rst_ready0", 32'(b3.req0_ready), 32'd0);
        check("t5_rst_ready1", 32'(b3.req1_ready), 32'd0);
        check("t5_rst_addr",   b3.mem_rd_addr,     32'd0);
        check("t5_rst_rsp1_d", b3.rsp1_data,       32'd0);
        check("t5_rst_rsp0_v", 32'(b3.rsp0_valid), 32'd0);
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("t5_rsp0_v_%0d", c), 32'(b3.rsp0_valid), 32'd0);
            check($sformatf("t5_rsp1_v_%0d", c), 32'(b3.rsp1_valid), 32'd0);
            next_cycle();
        end
        b3.req0_valid = 1'b1;
        b3.req0_addr  = 32'h210;
        b3.req1_valid = 1'b1;
        b3.req1_addr  = 32'h310;
        @(negedge clk);
        check("t5_post_ready0", 32'(b3.req0_ready), 32'd1);
        check("t5_post_ready1", 32'(b3.req1_ready), 32'd0);
        next_cycle();
        clear_inputs();

        // 6: idle after a read of 0x24 keeps the address and outputs quiet
        b1.req1_valid = 1'b1;
        b1.req1_addr  = 32'h24;
        @(negedge clk);
        check("t6_ready1_c0", 32'(b1.req1_ready), 32'd1);
        next_cycle();
        clear_inputs();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t6_addr_%0d", c),   b1.mem_rd_addr,     32'h24);
            check($sformatf("t6_ready0_%0d", c), 32'(b1.req0_ready), 32'd0);
            check($sformatf("t6_ready1_%0d", c), 32'(b1.req1_ready), 32'd0);
            check($sformatf("t6_rsp0_v_%0d", c), 32'(b1.rsp0_valid), 32'd0);
            check($sformatf("t6_rsp1_v_%0d", c), 32'(b1.rsp1_valid), 32'(c == 1));
            if (c == 1) check("t6_rsp1_d", b1.rsp1_data, 32'hD000_0024);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
